// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU: field layout, opcode map and form helpers.
// Used by decode, execute and the operand-A mux.
package cpu19_pkg;

   localparam int IW      = 19;
   localparam int IMMW    = 14;
   localparam int RIW     = 4;
   localparam int OPW     = 5;
   localparam int NUM_OPS = 24;

   localparam int OPC_LSB = 14;
   localparam int RD_LSB  = 10;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 2;
   localparam int IMM_LSB = 0;

   localparam logic [OPW-1:0] OP_LIMIT = OPW'(NUM_OPS);

   // Opcodes with bit 4 set take the zero-extended immediate as operand A.
   typedef enum logic [OPW-1:0] {
      OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND  = 5'h02, OP_OR   = 5'h03,
      OP_XOR  = 5'h04, OP_SLL  = 5'h05, OP_SRL  = 5'h06, OP_SRA  = 5'h07,
      OP_SLT  = 5'h08, OP_SLTU = 5'h09, OP_MUL  = 5'h0A, OP_LD   = 5'h0B,
      OP_ST   = 5'h0C, OP_BEQ  = 5'h0D, OP_BNE  = 5'h0E, OP_JR   = 5'h0F,
      OP_ADDI = 5'h10, OP_ANDI = 5'h11, OP_ORI  = 5'h12, OP_XORI = 5'h13,
      OP_LUI  = 5'h14, OP_LDI  = 5'h15, OP_JAL  = 5'h16, OP_BRI  = 5'h17
   } opcode_e;

   function automatic logic is_imm_form(input logic [OPW-1:0] opc);
      return opc[OPW-1];
   endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of a 19-bit instruction word into fields,
// plus operand-form and illegal-opcode classification.
module instr_field_split
   import cpu19_pkg::*;
(
   input  logic [IW-1:0]   i_instr,
   output logic [OPW-1:0]  o_opcode,
   output logic [RIW-1:0]  o_rd,
   output logic [RIW-1:0]  o_rs1,
   output logic [RIW-1:0]  o_rs2,
   output logic [IMMW-1:0] o_imm,
   output logic            o_sel_a,
   output logic            o_illegal
);

   logic [OPW-1:0] w_opcode;

   assign w_opcode  = i_instr[OPC_LSB +: OPW];
   assign o_opcode  = w_opcode;
   assign o_rd      = i_instr[RD_LSB  +: RIW];
   assign o_rs1     = i_instr[RS1_LSB +: RIW];
   assign o_rs2     = i_instr[RS2_LSB +: RIW];
   // Raw field; zero-extension happens in the operand mux.
   assign o_imm     = i_instr[IMM_LSB +: IMMW];
   assign o_sel_a   = ~is_imm_form(w_opcode);
   assign o_illegal = (w_opcode >= OP_LIMIT);

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: one-entry valid/ready pipeline register holding decoded fields,
// with flush, illegal-opcode flag and delivered-instruction counter.
//
//   state | meaning
//   EMPTY | no instruction held; accepting
//   FULL  | decoded instruction presented downstream
module instr_decode_stage
   import cpu19_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IW-1:0]   in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OPW-1:0]  opcode,
   output logic [RIW-1:0]  rd,
   output logic [RIW-1:0]  rs1,
   output logic [RIW-1:0]  rs2,
   output logic [IMMW-1:0] imm,
   output logic            sel_a,
   output logic            illegal,
   output logic [15:0]     instr_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic            w_in_ready;
   logic            w_capture;
   logic            w_xfer;

   logic [OPW-1:0]  w_opcode;
   logic [RIW-1:0]  w_rd;
   logic [RIW-1:0]  w_rs1;
   logic [RIW-1:0]  w_rs2;
   logic [IMMW-1:0] w_imm;
   logic            w_sel_a;
   logic            w_illegal;

   logic [OPW-1:0]  r_opcode;
   logic [RIW-1:0]  r_rd;
   logic [RIW-1:0]  r_rs1;
   logic [RIW-1:0]  r_rs2;
   logic [IMMW-1:0] r_imm;
   logic            r_sel_a;
   logic            r_illegal;
   logic [15:0]     r_count;

   instr_field_split u_split (
      .i_instr   (in_instr),
      .o_opcode  (w_opcode),
      .o_rd      (w_rd),
      .o_rs1     (w_rs1),
      .o_rs2     (w_rs2),
      .o_imm     (w_imm),
      .o_sel_a   (w_sel_a),
      .o_illegal (w_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Flush wins: no capture, no counted transfer, and the stage empties.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_capture   = 1'b0;
      w_xfer      = 1'b0;
      if (!flush) begin
         w_in_ready = (r_state == EMPTY) ? 1'b1 : out_ready;
         w_capture  = in_valid & w_in_ready;
         w_xfer     = (r_state == FULL) & out_ready;
      end
      if (flush)          w_state_nxt = EMPTY;
      else if (w_capture) w_state_nxt = FULL;
      else if (w_xfer)    w_state_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode  <= '0;
         r_rd      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_imm     <= '0;
         r_sel_a   <= 1'b1;
         r_illegal <= 1'b0;
      end else if (w_capture) begin
         r_opcode  <= w_opcode;
         r_rd      <= w_rd;
         r_rs1     <= w_rs1;
         r_rs2     <= w_rs2;
         r_imm     <= w_imm;
         r_sel_a   <= w_sel_a;
         r_illegal <= w_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_count <= '0;
      else if (w_xfer) r_count <= r_count + 16'd1;
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = (r_state == FULL);
   assign opcode      = r_opcode;
   assign rd          = r_rd;
   assign rs1         = r_rs1;
   assign rs2         = r_rs2;
   assign imm         = r_imm;
   assign sel_a       = r_sel_a;
   assign illegal     = r_illegal;
   assign instr_count = r_count;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: reset, form decode, backpressure,
// streaming, illegal opcodes, flush, mid-handshake reset and counter wrap.
module tb_instr_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  opcode;
   logic [3:0]  rd;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [13:0] imm;
   logic        sel_a;
   logic        illegal;
   logic [15:0] instr_count;

   int n_chk  = 0;
   int n_pass = 0;
   logic [15:0] exp_cnt;
   int t;

   instr_decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .opcode      (opcode),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .sel_a       (sel_a),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [18:0] mk(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 2'b01};
   endfunction

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_instr  = 19'h4_3FFF;
      exp_cnt   = 16'd0;

      // reset with in_valid held high
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", instr_count, 0);
      chk("rst_sel_a", sel_a, 1);
      chk("rst_illegal", illegal, 0);
      chk("rst_opcode", opcode, 0);
      rst_n = 1'b1;
      chk("post_rst_out_valid", out_valid, 0);

      // immediate form, one-cycle latency
      cyc();
      chk("imm_out_valid", out_valid, 1);
      chk("imm_opcode", opcode, 5'h10);
      chk("imm_imm", imm, 14'h3FFF);
      chk("imm_sel_a", sel_a, 0);
      chk("imm_illegal", illegal, 0);
      in_valid = 1'b0;
      cyc();
      chk("imm_count", instr_count, 1);
      chk("imm_drained", out_valid, 0);
      exp_cnt = 16'd1;

      // register form
      in_valid = 1'b1;
      in_instr = mk(5'h03, 4'hA, 4'h5, 4'hC);
      cyc();
      in_valid = 1'b0;
      chk("reg_sel_a", sel_a, 1);
      chk("reg_opcode", opcode, 5'h03);
      chk("reg_rd", rd, 4'hA);
      chk("reg_rs1", rs1, 4'h5);
      chk("reg_rs2", rs2, 4'hC);
      chk("reg_imm", imm, 14'h2971);
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      chk("reg_count", instr_count, exp_cnt);

      // backpressure
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_instr  = mk(5'h01, 4'h7, 4'h2, 4'h3);
      cyc();
      for (int i = 0; i < 5; i++) begin
         in_instr = mk(5'h02, 4'(i + 8), 4'h1, 4'h1);
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_rd_hold", rd, 4'h7);
         chk("bp_count_hold", instr_count, exp_cnt);
      end
      out_ready = 1'b1;
      in_instr  = mk(5'h04, 4'h9, 4'h6, 4'hE);
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_release_count", instr_count, exp_cnt);
      chk("bp_release_valid", out_valid, 1);
      chk("bp_new_rd", rd, 4'h9);
      chk("bp_new_rs2", rs2, 4'hE);
      in_valid = 1'b0;
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_drain_count", instr_count, exp_cnt);

      // streaming 10 back-to-back
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_instr = mk(5'(i + 1), 4'(i), 4'h0, 4'h0);
         cyc();
         chk("st_out_valid", out_valid, 1);
         chk("st_opcode", opcode, 32'(i + 1));
      end
      in_valid = 1'b0;
      cyc();
      exp_cnt = exp_cnt + 16'd10;
      chk("st_count", instr_count, exp_cnt);
      chk("st_drained", out_valid, 0);

      // illegal opcodes and the NUM_OPS boundary
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_instr  = mk(5'h1F, 4'h1, 4'h2, 4'h3);
      cyc();
      chk("ill_1f", illegal, 1);
      chk("ill_1f_sel_a", sel_a, 0);
      out_ready = 1'b1;
      in_instr  = mk(5'h18, 4'h0, 4'h0, 4'h0);
      cyc();
      chk("ill_1f_counted", instr_count, exp_cnt + 16'd1);
      chk("ill_18", illegal, 1);
      in_instr = mk(5'h17, 4'h0, 4'h0, 4'h0);
      cyc();
      chk("ill_17_legal", illegal, 0);
      chk("ill_17_sel_a", sel_a, 0);
      in_instr = mk(5'h0F, 4'h0, 4'h0, 4'h0);
      cyc();
      chk("ill_0f_legal", illegal, 0);
      chk("ill_0f_sel_a", sel_a, 1);
      in_valid = 1'b0;
      cyc();
      exp_cnt = exp_cnt + 16'd4;
      chk("ill_count", instr_count, exp_cnt);

      // flush while FULL with transfer and new word offered
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_instr  = mk(5'h05, 4'h3, 4'h3, 4'h3);
      cyc();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_instr  = mk(5'h06, 4'hD, 4'hD, 4'hD);
      #1;
      chk("fl_in_ready", in_ready, 0);
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_count", instr_count, exp_cnt);
      chk("fl_not_captured", rd, 4'h3);
      cyc();
      chk("fl_stays_empty", out_valid, 0);

      // reset mid-handshake
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_instr  = mk(5'h07, 4'h4, 4'h4, 4'h4);
      cyc();
      chk("mr_full", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", out_valid, 0);
      chk("mr_count", instr_count, 0);
      chk("mr_rd", rd, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 16'd0;

      // counter wrap
      t         = 32'(16'hFFFF - exp_cnt);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_instr  = mk(5'h00, 4'h1, 4'h1, 4'h1);
      repeat (t + 1) cyc();
      chk("wrap_ffff", instr_count, 16'hFFFF);
      in_valid = 1'b0;
      cyc();
      chk("wrap_zero", instr_count, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
